// File: rtl/flopr_pkg.sv
// Shared constants for the generic register slice.
// The processor-wide data width (64) is passed in by the datapath, not taken from here.
package flopr_pkg;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/flopr.sv
// Parameterized D register with synchronous active-high reset.
// Used for the program counter and other registered values of the single-cycle datapath.
module flopr
   import flopr_pkg::*;
#(
   parameter int                WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = d;
   end

   // Reset is checked only at the clock edge and overrides d; X/Z on d pass through.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= RESET_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: tb/tb_flopr.sv
// Self-checking bench for flopr at WIDTH 64, WIDTH 1 and WIDTH 16 with a non-zero reset value.
// Directed vectors from a table, hand sequences for hold behaviour, then random traffic vs a model.
module tb_flopr;

   logic        clk;
   logic        reset;
   logic [63:0] d64;
   logic [63:0] q64;
   logic        d1;
   logic        q1;
   logic [15:0] d16;
   logic [15:0] q16;

   int total;
   int bad;

   typedef struct {
      logic        rst;
      logic [63:0] d;
      logic [63:0] exp64;
      logic [15:0] exp16;
      logic        exp1;
   } vec_t;

   vec_t vecs[$];

   flopr #(.WIDTH(64)) dut64 (
      .clk   (clk),
      .reset (reset),
      .d     (d64),
      .q     (q64)
   );

   flopr #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .d     (d1),
      .q     (q1)
   );

   flopr #(.WIDTH(16), .RESET_VALUE(16'hDEAD)) dut16 (
      .clk   (clk),
      .reset (reset),
      .d     (d16),
      .q     (q16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives all three registers on the falling edge and returns just after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic [63:0] d);
      @(negedge clk);
      reset = rst;
      d64   = d;
      d16   = d[15:0];
      d1    = d[0];
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic rst, input logic [63:0] d, input logic [63:0] e64,
                         input logic [15:0] e16, input logic e1);
      vec_t v;
      v.rst = rst; v.d = d; v.exp64 = e64; v.exp16 = e16; v.exp1 = e1;
      vecs.push_back(v);
   endtask

   initial begin
      logic [63:0] held64;
      logic        rst_r;
      logic [63:0] d_r;
      logic [63:0] m64;
      logic [15:0] m16;
      logic        m1;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      d64   = '0;
      d16   = '0;
      d1    = 1'b0;

      addVec(1'b1, 64'h1,    64'h0,    16'hDEAD, 1'b0);
      addVec(1'b1, 64'hA2,   64'h0,    16'hDEAD, 1'b0);
      addVec(1'b1, 64'hBA,   64'h0,    16'hDEAD, 1'b0);
      addVec(1'b1, 64'h10,   64'h0,    16'hDEAD, 1'b0);
      addVec(1'b1, 64'h51,   64'h0,    16'hDEAD, 1'b0);
      addVec(1'b0, 64'hA2,   64'hA2,   16'h00A2, 1'b0);
      addVec(1'b0, 64'hCC,   64'hCC,   16'h00CC, 1'b0);
      addVec(1'b0, 64'h55,   64'h55,   16'h0055, 1'b1);
      addVec(1'b1, 64'h123,  64'h0,    16'hDEAD, 1'b0);
      addVec(1'b0, 64'h1010, 64'h1010, 16'h1010, 1'b0);
      addVec(1'b0, 64'h123,  64'h123,  16'h0123, 1'b1);
      addVec(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b1);
      addVec(1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 16'h0001, 1'b1);
      addVec(1'b0, 64'h0,    64'h0,    16'h0000, 1'b0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].d);
         checkOutput($sformatf("vec%0d_q64", i), q64, vecs[i].exp64);
         checkOutput($sformatf("vec%0d_q16", i), 64'(q16), 64'(vecs[i].exp16));
         checkOutput($sformatf("vec%0d_q1", i), 64'(q1), 64'(vecs[i].exp1));
      end

      // d wiggles between edges, including right at the falling edge; q must not move.
      applyStimulus(1'b0, 64'h0123_4567_89AB_CDEF);
      held64 = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      d64 = 64'h1111; d16 = 16'h1111; d1 = 1'b1;
      #1;
      checkOutput("hold_negedge_q64", q64, held64);
      checkOutput("hold_negedge_q16", 64'(q16), 64'h0000_0000_0000_CDEF);
      checkOutput("hold_negedge_q1", 64'(q1), 64'h1);
      d64 = 64'h2222; d16 = 16'h2222; d1 = 1'b0;
      reset = 1'b1;
      #2;
      checkOutput("hold_mid_q64", q64, held64);
      checkOutput("hold_mid_q16", 64'(q16), 64'h0000_0000_0000_CDEF);
      reset = 1'b0;
      d64 = 64'h3333; d16 = 16'h3333; d1 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("hold_capture_q64", q64, 64'h3333);
      checkOutput("hold_capture_q16", 64'(q16), 64'h3333);
      checkOutput("hold_capture_q1", 64'(q1), 64'h0);

      // Random traffic: the value after an edge is the reset value if reset was sampled, else d.
      for (int n = 0; n < 300; n++) begin
         rst_r = ($urandom_range(0, 7) == 0);
         d_r   = {$urandom(), $urandom()};
         m64   = rst_r ? 64'h0 : d_r;
         m16   = rst_r ? 16'hDEAD : d_r[15:0];
         m1    = rst_r ? 1'b0 : d_r[0];
         applyStimulus(rst_r, d_r);
         checkOutput("rand_q64", q64, m64);
         checkOutput("rand_q16", 64'(q16), 64'(m16));
         checkOutput("rand_q1", 64'(q1), 64'(m1));
         #2;
         d64 = ~d_r; d16 = ~d_r[15:0]; d1 = ~d_r[0];
         reset = ~rst_r;
         #1;
         checkOutput("rand_stable_q64", q64, m64);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
